rf_wb_scheduler: RTL and testbench
==================================

# rf_wb_scheduler

Write-back scheduler and hazard scoreboard for the RiSC-16 8×16 register file. It tracks which registers have an in-flight write and stalls issue on RAW/WAW hazards. It also arbitrates two write-back sources (ALU and memory load) onto the register file's single write port (`we_rf`/`tgt`/`tgt_val`). It sits between the decode/issue stage, the execution units and the register file.

## Interface
- No parameters; register count (8) and data width (16) are fixed by the ISA.
- `clk` in 1: system clock; state updates on posedge, register file latches on negedge.
- `rst` in 1: synchronous, active-high reset.
- `iss_valid` in 1: decode presents an instruction.
- `iss_src1`, `iss_src2` in 3: operand registers of the presented instruction.
- `iss_tgt` in 3: destination register; 0 = no write.
- `stall` out 1: combinational; instruction not accepted this cycle.
- `alu_valid` in 1, `alu_tgt` in 3, `alu_val` in 16: ALU write-back request.
- `alu_ready` out 1: combinational ALU grant.
- `mem_valid` in 1, `mem_tgt` in 3, `mem_val` in 16: load write-back request.
- `mem_ready` out 1: combinational load grant.
- `we_rf` out 1, `tgt` out 3, `tgt_val` out 16: registered register-file write port.
- `pend` out 8: scoreboard bits; bit 0 is always 0.
- `idle` out 1: `pend == 0` and `we_rf == 0`.

## Operation
- **Scoreboard.**
  - `hazard` = `pend[iss_src1] | pend[iss_src2] | pend[iss_tgt]`, evaluated only for nonzero indices.
  - `stall = iss_valid & hazard`.
  - An issue is accepted when `iss_valid & !stall`.
  - On acceptance with `iss_tgt != 0`, `pend[iss_tgt]` is set at the next posedge.
- **Write-back handshake.**
  - A transfer occurs when `valid & ready`.
  - A source holds `valid`, `tgt` and `val` stable until `ready`.
  - At most one grant per cycle; `ready` never asserts without `valid`.
- **Arbitration.** If only one source is valid, it is granted. If both are valid, priority depends on `RF_RR_ARB_EN`.
- **On a granted transfer at posedge:**
  - `we_rf <= (tgt != 0)`, `tgt <= granted tgt`, `tgt_val <= granted val`.
  - `pend[granted tgt]` is cleared at the same edge.
  - With no transfer, `we_rf <= 0`; `tgt`/`tgt_val` hold their values.
- **Write-back to r0.** The handshake completes, `we_rf` stays 0, and `pend` is unchanged.
- **Write-back to a non-pending register.** The write is still performed; no error is flagged.
- **Simultaneous set and clear of the same bit.** The set wins: the new issue's write is still outstanding.
- **Reset.** `pend = 0`, `we_rf = 0`, `tgt = 0`, `tgt_val = 0`, round-robin pointer favours the load source. Reset mid-operation discards all pending bits and any write registered but not yet latched. Sources must drop `valid` during reset; `ready` is forced to 0 while `rst` is high.

## Timing
- Issue to `pend` set: 1 cycle.
- Grant cycle N: `we_rf` high during cycle N+1; the register file latches at the negedge in N+1.
- `pend` clears at the start of N+1. A dependent instruction can be accepted in N+1; its operands are valid after that negedge and are sampled at the N+2 posedge.
- Write-port throughput: one write per cycle. Each source can be granted back-to-back.
- `stall`, `alu_ready` and `mem_ready` are combinational from inputs and state; there is no path from `ready` to `valid`.

## Configuration
- **`RF_RR_ARB_EN` defined:** round-robin arbitration. On conflict, the source not granted most recently wins, and the pointer updates only on a conflicting grant.
- **`RF_RR_ARB_EN` undefined:** fixed priority, load before ALU. The pointer logic is removed.

## Test plan
- Issue `r3 <- ...` (`iss_tgt=3`), then issue an instruction reading `r3` -> `stall=1` until ALU write-back `tgt=3`, `val=16'h1234` is granted. `pend[3]` clears on that edge, the next-cycle issue is accepted, and `we_rf=1`, `tgt=3`, `tgt_val=16'h1234`.
- Both sources valid for 4 cycles (`alu tgt=1`, `mem tgt=2`):
  - With `RF_RR_ARB_EN`: grants are mem, alu, mem, alu.
  - Without it: mem is granted every cycle and `alu_ready` stays 0.
- Issue `iss_tgt=0` and `iss_src1=0` with all registers pending -> no stall, `pend` unchanged. Write-back to r0 -> `ready=1`, `we_rf=0`.
- Write-back clears `pend[5]` in the same cycle a new issue targets r5 -> `pend[5]=1` afterwards.
- Assert `rst` while `pend=8'hFE` and `we_rf=1` -> next cycle `pend=0`, `we_rf=0`, `tgt=0`, `tgt_val=0`, `idle=1`.
- WAW: `pend[4]=1`, issue `iss_tgt=4` with clean sources -> `stall=1` until `r4`'s write-back is granted.

Source files
------------

// File: rtl/rf_wb_scheduler.sv
// RiSC-16 write-back scheduler: RAW/WAW hazard scoreboard plus ALU/load arbitration
// onto the single register-file write port. Define RF_RR_ARB_EN for round-robin arbitration.
module rf_wb_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        iss_valid,
  input  logic [2:0]  iss_src1,
  input  logic [2:0]  iss_src2,
  input  logic [2:0]  iss_tgt,
  output logic        stall,
  input  logic        alu_valid,
  input  logic [2:0]  alu_tgt,
  input  logic [15:0] alu_val,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [2:0]  mem_tgt,
  input  logic [15:0] mem_val,
  output logic        mem_ready,
  output logic        we_rf,
  output logic [2:0]  tgt,
  output logic [15:0] tgt_val,
  output logic [7:0]  pend,
  output logic        idle
);

  logic [7:0]  pend_q, pend_d;
  logic        we_rf_q, we_rf_d;
  logic [2:0]  tgt_q, tgt_d;
  logic [15:0] tgt_val_q, tgt_val_d;
  logic        hazard;
  logic        accept;
  logic        alu_wins;
  logic        grant;
  logic [2:0]  g_tgt;
  logic [15:0] g_val;

`ifdef RF_RR_ARB_EN
  // Set when the ALU took the most recent conflicting grant; reset value favours the load.
  logic        last_alu_q, last_alu_d;

  always_comb begin
    alu_wins   = ~last_alu_q;
    last_alu_d = last_alu_q;
    if (!rst && alu_valid && mem_valid) last_alu_d = alu_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) last_alu_q <= 1'b1;
    else     last_alu_q <= last_alu_d;
  end
`else
  always_comb alu_wins = 1'b0;
`endif

  always_comb begin
    hazard = ((iss_src1 != 3'd0) && pend_q[iss_src1]) ||
             ((iss_src2 != 3'd0) && pend_q[iss_src2]) ||
             ((iss_tgt  != 3'd0) && pend_q[iss_tgt]);
    stall  = iss_valid & hazard;
    accept = iss_valid & ~hazard;

    alu_ready = ~rst & alu_valid & (~mem_valid | alu_wins);
    mem_ready = ~rst & mem_valid & (~alu_valid | ~alu_wins);
    grant     = alu_ready | mem_ready;
    g_tgt     = alu_ready ? alu_tgt : mem_tgt;
    g_val     = alu_ready ? alu_val : mem_val;

    pend_d    = pend_q;
    we_rf_d   = 1'b0;
    tgt_d     = tgt_q;
    tgt_val_d = tgt_val_q;
    if (grant) begin
      we_rf_d   = (g_tgt != 3'd0);
      tgt_d     = g_tgt;
      tgt_val_d = g_val;
      pend_d[g_tgt] = 1'b0;
    end
    // Set applied after clear so a same-cycle issue to the retiring register stays pending.
    if (accept && (iss_tgt != 3'd0)) pend_d[iss_tgt] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= '0;
      we_rf_q   <= 1'b0;
      tgt_q     <= '0;
      tgt_val_q <= '0;
    end else begin
      pend_q    <= pend_d;
      we_rf_q   <= we_rf_d;
      tgt_q     <= tgt_d;
      tgt_val_q <= tgt_val_d;
    end
  end

  assign we_rf   = we_rf_q;
  assign tgt     = tgt_q;
  assign tgt_val = tgt_val_q;
  assign pend    = pend_q;
  assign idle    = (pend_q == 8'd0) && !we_rf_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Scoreboard bench for rf_wb_scheduler: a reference model predicts grants and register-file
// writes, queues the expected write port value and compares it after the clock edge.
module tb_rf_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid;
  logic [2:0]  iss_src1, iss_src2, iss_tgt;
  logic        stall;
  logic        alu_valid;
  logic [2:0]  alu_tgt;
  logic [15:0] alu_val;
  logic        alu_ready;
  logic        mem_valid;
  logic [2:0]  mem_tgt;
  logic [15:0] mem_val;
  logic        mem_ready;
  logic        we_rf;
  logic [2:0]  tgt;
  logic [15:0] tgt_val;
  logic [7:0]  pend;
  logic        idle;

  rf_wb_scheduler dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_tgt(iss_tgt),
    .stall(stall),
    .alu_valid(alu_valid), .alu_tgt(alu_tgt), .alu_val(alu_val), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_tgt(mem_tgt), .mem_val(mem_val), .mem_ready(mem_ready),
    .we_rf(we_rf), .tgt(tgt), .tgt_val(tgt_val), .pend(pend), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [2:0]  t;
    logic [15:0] v;
  } wb_t;

  wb_t         exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [7:0]  pend_m = '0;
  logic        last_alu_m = 1'b1;
  logic [2:0]  tgt_m = '0;
  logic [15:0] val_m = '0;
  logic        obs_ar, obs_mr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs mid-cycle, advance model, check registered outputs.
  task automatic cyc();
    logic        haz, aw, e_ar, e_mr, g;
    logic [2:0]  gt;
    logic [15:0] gv;
    wb_t         e;
    @(negedge clk); #1;
    haz = ((iss_src1 != 0) && pend_m[iss_src1]) || ((iss_src2 != 0) && pend_m[iss_src2]) ||
          ((iss_tgt != 0) && pend_m[iss_tgt]);
`ifdef RF_RR_ARB_EN
    aw = ~last_alu_m;
`else
    aw = 1'b0;
`endif
    e_ar = !rst && alu_valid && (!mem_valid || aw);
    e_mr = !rst && mem_valid && (!alu_valid || !aw);
    chk("stall", stall, iss_valid && haz);
    chk("alu_ready", alu_ready, e_ar);
    chk("mem_ready", mem_ready, e_mr);
    obs_ar = alu_ready;
    obs_mr = mem_ready;
    if (rst) begin
      pend_m = '0; last_alu_m = 1'b1; tgt_m = '0; val_m = '0;
      exp_q.push_back('{1'b0, 3'd0, 16'd0});
    end else begin
      g  = e_ar || e_mr;
      gt = e_ar ? alu_tgt : mem_tgt;
      gv = e_ar ? alu_val : mem_val;
      if (alu_valid && mem_valid) last_alu_m = e_ar;
      if (g) begin
        if (gt != 0) pend_m[gt] = 1'b0;
        tgt_m = gt; val_m = gv;
      end
      if (iss_valid && !haz && iss_tgt != 0) pend_m[iss_tgt] = 1'b1;
      exp_q.push_back('{g && (gt != 0), tgt_m, val_m});
    end
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("we_rf", we_rf, e.we);
      chk("tgt", tgt, e.t);
      chk("tgt_val", tgt_val, e.v);
      chk("pend", pend, pend_m);
      chk("idle", idle, (pend_m == 0) && !e.we);
    end
  endtask

  task automatic set_iss(input logic v, input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] t);
    iss_valid = v; iss_src1 = s1; iss_src2 = s2; iss_tgt = t;
  endtask

  initial begin
    rst = 1'b1;
    set_iss(0, 0, 0, 0);
    alu_valid = 0; alu_tgt = 0; alu_val = 0;
    mem_valid = 0; mem_tgt = 0; mem_val = 0;
    cyc();
    cyc();
    chk("reset_pend", pend, 8'h00);
    chk("reset_idle", idle, 1'b1);
    rst = 1'b0;

    // RAW on r3 resolved by ALU write-back
    set_iss(1, 1, 2, 3); cyc();
    set_iss(1, 3, 0, 0); cyc();
    chk("raw_stall", stall, 1'b1);
    cyc();
    alu_valid = 1; alu_tgt = 3; alu_val = 16'h1234; cyc();
    alu_valid = 0; cyc();
    chk("raw_we", we_rf, 1'b0);
    set_iss(0, 0, 0, 0);

    // Both sources contending for four cycles
    alu_valid = 1; alu_tgt = 1; alu_val = 16'hA1A1;
    mem_valid = 1; mem_tgt = 2;
    for (int i = 0; i < 4; i++) begin
      mem_val = 16'hB000 + 16'(i);
      cyc();
`ifdef RF_RR_ARB_EN
      chk("arb_mem", obs_mr, (i % 2) == 0);
      chk("arb_alu", obs_ar, (i % 2) == 1);
`else
      chk("arb_mem", obs_mr, 1'b1);
      chk("arb_alu", obs_ar, 1'b0);
`endif
    end
    alu_valid = 0; mem_valid = 0; cyc();

    // Write-back to non-pending r5 with a same-cycle issue to r5: set wins
    alu_valid = 1; alu_tgt = 5; alu_val = 16'h0555;
    set_iss(1, 0, 0, 5); cyc();
    chk("setwins_pend5", pend[5], 1'b1);
    alu_valid = 0;

    // WAW on r5 until its load write-back is granted
    set_iss(1, 0, 0, 5); cyc();
    chk("waw_stall", obs_ar | stall, 1'b1);
    mem_valid = 1; mem_tgt = 5; mem_val = 16'h5A5A; cyc();
    mem_valid = 0; cyc();
    chk("waw_accept_pend5", pend[5], 1'b1);

    // Fill the scoreboard, then r0 issue and r0 write-back
    for (int r = 1; r < 8; r++) begin
      set_iss(1, 0, 0, 3'(r)); cyc();
    end
    set_iss(1, 0, 0, 0); cyc();
    chk("full_pend", pend, 8'hFE);
    set_iss(0, 0, 0, 0);
    alu_valid = 1; alu_tgt = 0; alu_val = 16'hDEAD; cyc();
    chk("r0_ready", obs_ar, 1'b1);
    chk("r0_we", we_rf, 1'b0);
    chk("r0_pend", pend, 8'hFE);

    // Reach pend=FE with we_rf=1, then reset
    alu_tgt = 6; alu_val = 16'h0666; cyc();
    alu_val = 16'h0667; set_iss(1, 0, 0, 6); cyc();
    chk("pre_rst_pend", pend, 8'hFE);
    chk("pre_rst_we", we_rf, 1'b1);
    alu_valid = 0; set_iss(0, 0, 0, 0);
    rst = 1'b1; cyc();
    rst = 1'b0;
    chk("rst_pend", pend, 8'h00);
    chk("rst_tgt_val", tgt_val, 16'h0000);
    chk("rst_idle", idle, 1'b1);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
